ysyx_23060111_gpr: RTL

General-purpose register file for the NPC core with configurable address and data width, two asynchronous read ports and one synchronous write port. Register 0 is hard-wired to zero. The block adds three things to the basic register file: a per-register pending-write scoreboard for hazard detection, a post-reset sweep that clears every register to zero, and an optional same-cycle write-to-read bypass. It sits between decode (reads, scoreboard allocation) and writeback (register writes).

---
 rtl/ysyx_23060111_gpr_if.sv | 30 +++
 rtl/ysyx_23060111_gpr.sv | 101 ++++++++++
 2 files changed

// File: rtl/ysyx_23060111_gpr_if.sv
// Decode/writeback-facing bundle of the NPC register file: write port, two read ports
// and the pending-write scoreboard controls.
interface ysyx_23060111_gpr_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                  ready;
  logic                  wen;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [ADDR_WIDTH-1:0] raddr1;
  logic [ADDR_WIDTH-1:0] raddr2;
  logic [DATA_WIDTH-1:0] rdata1;
  logic [DATA_WIDTH-1:0] rdata2;
  logic                  rbusy1;
  logic                  rbusy2;
  logic                  alloc_en;
  logic [ADDR_WIDTH-1:0] alloc_addr;
  logic                  flush;

  modport master (
    input  ready, rdata1, rdata2, rbusy1, rbusy2,
    output wen, waddr, wdata, raddr1, raddr2, alloc_en, alloc_addr, flush
  );

  modport slave (
    output ready, rdata1, rdata2, rbusy1, rbusy2,
    input  wen, waddr, wdata, raddr1, raddr2, alloc_en, alloc_addr, flush
  );
endinterface

// File: rtl/ysyx_23060111_gpr.sv
// NPC register file with pending-write scoreboard and post-reset clear sweep.
// Optional same-cycle write-to-read bypass enabled by YSYX_23060111_GPR_BYPASS_EN.
//
// state  | meaning
// S_INIT | sweeping rf[r_cnt] <= 0, all ports gated off
// S_RUN  | normal operation, ready=1
module ysyx_23060111_gpr #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  ysyx_23060111_gpr_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [DEPTH-1:0]      r_pend;
  logic [DEPTH-1:0]      w_pend_nxt;
  logic [DATA_WIDTH-1:0] r_rf [DEPTH];

  logic                  w_run;
  logic                  w_wr;
  logic [DATA_WIDTH-1:0] w_rd1;
  logic [DATA_WIDTH-1:0] w_rd2;
  logic                  w_pb1;
  logic                  w_pb2;

  assign w_run = (r_state == S_RUN);
  assign w_wr  = w_run && bus.wen && (bus.waddr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_INIT;
      r_cnt   <= '0;
      r_pend  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
      if (r_state == S_INIT) r_cnt <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_INIT:  if (r_cnt == '1) w_state_nxt = S_RUN;
      S_RUN:   w_state_nxt = S_RUN;
      default: w_state_nxt = S_INIT;
    endcase
  end

  // Set after clear so a same-cycle re-allocation beats the retiring writeback.
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_run) begin
      if (bus.flush) begin
        w_pend_nxt = '0;
      end else begin
        if (bus.wen) w_pend_nxt[bus.waddr] = 1'b0;
        if (bus.alloc_en && (bus.alloc_addr != '0)) w_pend_nxt[bus.alloc_addr] = 1'b1;
      end
    end
  end

  // Contents are not reset; the sweep is what makes them defined.
  always_ff @(posedge clk) begin
    if (r_state == S_INIT) r_rf[r_cnt] <= '0;
    else if (w_wr)         r_rf[bus.waddr] <= bus.wdata;
  end

  assign w_rd1 = (w_run && (bus.raddr1 != '0)) ? r_rf[bus.raddr1] : '0;
  assign w_rd2 = (w_run && (bus.raddr2 != '0)) ? r_rf[bus.raddr2] : '0;
  assign w_pb1 = w_run && (bus.raddr1 != '0) && r_pend[bus.raddr1];
  assign w_pb2 = w_run && (bus.raddr2 != '0) && r_pend[bus.raddr2];

  assign bus.ready = w_run;

`ifdef YSYX_23060111_GPR_BYPASS_EN
  logic w_realloc;
  logic w_byp1;
  logic w_byp2;

  assign w_realloc  = bus.alloc_en && (bus.alloc_addr == bus.waddr);
  assign w_byp1     = w_wr && (bus.waddr == bus.raddr1);
  assign w_byp2     = w_wr && (bus.waddr == bus.raddr2);
  assign bus.rdata1 = w_byp1 ? bus.wdata : w_rd1;
  assign bus.rdata2 = w_byp2 ? bus.wdata : w_rd2;
  assign bus.rbusy1 = w_byp1 ? (w_realloc && w_pb1) : w_pb1;
  assign bus.rbusy2 = w_byp2 ? (w_realloc && w_pb2) : w_pb2;
`else
  assign bus.rdata1 = w_rd1;
  assign bus.rdata2 = w_rd2;
  assign bus.rbusy1 = w_pb1;
  assign bus.rbusy2 = w_pb2;
`endif
endmodule
